// File: rtl/shift_normalizer32.sv
// Multicycle normalizer: binary-search for the shift that brings the first set bit to the MSB
// (left mode) or LSB (right mode), one search stage of 16/8/4/2/1 per cycle.
module shift_normalizer32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] D,
    input  logic             LnR,
    output logic [WIDTH-1:0] Y,
    output logic [CNT_W-1:0] CNT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;
    logic             left_q, left_d;
    logic             zeroOp_q, zeroOp_d;
    logic [WIDTH-1:0] yOut_q, yOut_d;
    logic [CNT_W-1:0] cntOut_q, cntOut_d;
    logic             zeroOut_q, zeroOut_d;

    logic [CNT_W-1:0] stageAmt;
    logic [WIDTH-1:0] stageMask;
    logic [WIDTH-1:0] stageShifted;
    logic             stageHit;
    logic [WIDTH-1:0] stageWork;
    logic [CNT_W-1:0] stageCnt;

    // Current stage: test the 2^k bits at the edge we normalize toward, shift them out if all zero.
    always_comb begin
        stageAmt     = CNT_W'(1) << step_q;
        stageMask    = left_q ? ~({WIDTH{1'b1}} >> stageAmt) : ~({WIDTH{1'b1}} << stageAmt);
        stageShifted = left_q ? (work_q << stageAmt) : (work_q >> stageAmt);
        stageHit     = ((work_q & stageMask) == '0);
        stageWork    = stageHit ? stageShifted : work_q;
        stageCnt     = stageHit ? (cnt_q + stageAmt) : cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        left_d    = left_q;
        zeroOp_d  = zeroOp_q;
        yOut_d    = yOut_q;
        cntOut_d  = cntOut_q;
        zeroOut_d = zeroOut_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    work_d   = D;
                    left_d   = LnR;
                    cnt_d    = '0;
                    step_d   = 3'd4;
                    zeroOp_d = (D == '0);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = stageWork;
                cnt_d  = stageCnt;
                if (step_q == 3'd0) begin
                    // A zero operand passes every stage (sum 31), so the full-width count is forced.
                    yOut_d    = stageWork;
                    cntOut_d  = zeroOp_q ? CNT_W'(WIDTH) : stageCnt;
                    zeroOut_d = zeroOp_q;
                    state_d   = ST_DONE;
                end else begin
                    step_d = step_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            step_q    <= '0;
            left_q    <= 1'b0;
            zeroOp_q  <= 1'b0;
            yOut_q    <= '0;
            cntOut_q  <= '0;
            zeroOut_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            left_q    <= left_d;
            zeroOp_q  <= zeroOp_d;
            yOut_q    <= yOut_d;
            cntOut_q  <= cntOut_d;
            zeroOut_q <= zeroOut_d;
        end
    end

    assign Y    = yOut_q;
    assign CNT  = cntOut_q;
    assign ZERO = zeroOut_q;
    assign BUSY = (state_q != ST_IDLE);
    assign DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_normalizer32.sv
// Self-checking bench for shift_normalizer32: directed cases plus random operands
// compared against a bit-scan reference model.
module tb_shift_normalizer32;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [31:0] D;
    logic        LnR;
    logic [31:0] Y;
    logic [5:0]  CNT;
    logic        ZERO;
    logic        BUSY;
    logic        DONE;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expY;
    logic [5:0]  expCnt;
    logic        expZero;

    shift_normalizer32 #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .D    (D),
        .LnR  (LnR),
        .Y    (Y),
        .CNT  (CNT),
        .ZERO (ZERO),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: scan bit by bit for the first set bit from the normalizing side.
    task automatic refNorm(input logic [31:0] d, input logic lnr,
                           output logic [31:0] y, output logic [5:0] c, output logic z);
        int n;
        n = 0;
        if (d == 32'd0) begin
            y = 32'd0;
            c = 6'd32;
            z = 1'b1;
        end else begin
            if (lnr) begin
                while (d[31 - n] == 1'b0) n++;
                y = d << n;
            end else begin
                while (d[n] == 1'b0) n++;
                y = d >> n;
            end
            c = 6'(n);
            z = 1'b0;
        end
    endtask

    // One complete operation; busy cycles are filled with junk START/D/LnR that must be ignored.
    task automatic applyStimulus(input logic [31:0] d, input logic lnr);
        logic [31:0] ny;
        logic [5:0]  nc;
        logic        nz;
        refNorm(d, lnr, ny, nc, nz);
        START = 1'b1;
        D     = d;
        LnR   = lnr;
        tick();
        checkOutput("busy_after_start", 32'(BUSY), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            START = 1'($urandom_range(0, 1));
            D     = $urandom;
            LnR   = 1'($urandom_range(0, 1));
            tick();
            if (i < 5) begin
                checkOutput("no_early_done", 32'(DONE), 32'd0);
                checkOutput("busy_mid", 32'(BUSY), 32'd1);
                checkOutput("y_holds_prev", Y, expY);
                checkOutput("cnt_holds_prev", 32'(CNT), 32'(expCnt));
            end
        end
        START = 1'b0;
        checkOutput("done_pulse", 32'(DONE), 32'd1);
        checkOutput("busy_in_done", 32'(BUSY), 32'd1);
        checkOutput("y_result", Y, ny);
        checkOutput("cnt_result", 32'(CNT), 32'(nc));
        checkOutput("zero_result", 32'(ZERO), 32'(nz));
        expY    = ny;
        expCnt  = nc;
        expZero = nz;
        tick();
        checkOutput("done_one_cycle", 32'(DONE), 32'd0);
        checkOutput("idle_not_busy", 32'(BUSY), 32'd0);
        checkOutput("y_held", Y, expY);
        checkOutput("cnt_held", 32'(CNT), 32'(expCnt));
    endtask

    initial begin
        logic [31:0] rd;
        logic        rl;

        // Reset state
        RST   = 1'b1;
        START = 1'b0;
        D     = 32'd0;
        LnR   = 1'b0;
        tick();
        tick();
        checkOutput("rst_y", Y, 32'd0);
        checkOutput("rst_cnt", 32'(CNT), 32'd0);
        checkOutput("rst_zero", 32'(ZERO), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_done", 32'(DONE), 32'd0);
        RST     = 1'b0;
        expY    = 32'd0;
        expCnt  = 6'd0;
        expZero = 1'b0;
        tick();

        // Directed cases, with explicit constants for the headline ones
        applyStimulus(32'h0001_0000, 1'b1);
        checkOutput("left_16_cnt", 32'(CNT), 32'd15);
        checkOutput("left_16_y", Y, 32'h8000_0000);
        applyStimulus(32'h0001_0000, 1'b0);
        checkOutput("right_16_cnt", 32'(CNT), 32'd16);
        checkOutput("right_16_y", Y, 32'h0000_0001);
        applyStimulus(32'h8000_0000, 1'b0);
        checkOutput("right_msb_cnt", 32'(CNT), 32'd31);
        applyStimulus(32'h8000_0000, 1'b1);
        checkOutput("left_msb_cnt", 32'(CNT), 32'd0);
        applyStimulus(32'h0000_0001, 1'b1);
        checkOutput("left_lsb_cnt", 32'(CNT), 32'd31);
        checkOutput("left_lsb_y", Y, 32'h8000_0000);
        applyStimulus(32'h0000_0000, 1'b1);
        checkOutput("zero_left_cnt", 32'(CNT), 32'd32);
        checkOutput("zero_left_flag", 32'(ZERO), 32'd1);
        applyStimulus(32'h0000_0000, 1'b0);
        checkOutput("zero_right_cnt", 32'(CNT), 32'd32);
        applyStimulus(32'h0000_F000, 1'b1);
        checkOutput("busy_start_cnt", 32'(CNT), 32'd16);
        checkOutput("busy_start_y", Y, 32'hF000_0000);

        // Reset in the third SHIFT cycle discards the operation
        START = 1'b1;
        D     = 32'h0000_0100;
        LnR   = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("midrst_y", Y, 32'd0);
        checkOutput("midrst_cnt", 32'(CNT), 32'd0);
        checkOutput("midrst_zero", 32'(ZERO), 32'd0);
        checkOutput("midrst_busy", 32'(BUSY), 32'd0);
        checkOutput("midrst_done", 32'(DONE), 32'd0);
        expY    = 32'd0;
        expCnt  = 6'd0;
        expZero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("midrst_no_done", 32'(DONE), 32'd0);
        end
        applyStimulus(32'h0000_0100, 1'b1);
        checkOutput("after_rst_cnt", 32'(CNT), 32'd23);
        checkOutput("after_rst_y", Y, 32'h8000_0000);

        // START held high: one op every 7 cycles, one idle cycle between ops
        START = 1'b1;
        D     = 32'h00F0_0000;
        LnR   = 1'b1;
        for (int op = 0; op < 3; op++) begin
            tick();
            checkOutput("b2b_busy_start", 32'(BUSY), 32'd1);
            for (int i = 1; i <= 5; i++) begin
                tick();
                if (i < 5) checkOutput("b2b_no_early_done", 32'(DONE), 32'd0);
            end
            checkOutput("b2b_done", 32'(DONE), 32'd1);
            checkOutput("b2b_cnt", 32'(CNT), 32'd8);
            checkOutput("b2b_y", Y, 32'hF000_0000);
            tick();
            checkOutput("b2b_idle_gap", 32'(BUSY), 32'd0);
        end
        START   = 1'b0;
        expY    = 32'hF000_0000;
        expCnt  = 6'd8;
        expZero = 1'b0;
        tick();

        // Random operands spread across all leading/trailing-zero counts
        for (int n = 0; n < 40; n++) begin
            rl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                rd = 32'd0;
            end else begin
                rd = $urandom | 32'h1;
                if (rl) rd = rd >> $urandom_range(0, 31);
                else    rd = {rd[0], rd[31:1]} << $urandom_range(0, 31);
            end
            applyStimulus(rd, rl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
